// File: rtl/mips_ext_pkg.sv
// Shared definitions for the extended MIPS datapath front end:
// status bit positions, next-PC source selector, reset PC default.
package mips_ext_pkg;

  localparam int unsigned ST_V = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_Z = 2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_MEM,
    NPC_REG,
    NPC_JT,
    NPC_BT
  } npc_sel_t;

endpackage

// File: rtl/pc_status_unit_next_pc_sel.sv
// Combinational next-PC selection: builds branch/jump targets and picks
// the next PC from decoder strobes and the registered status flags.
module next_pc_sel
  import mips_ext_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instruc,
  input  logic [31:0] dataa,
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  status,
  input  logic        branch,
  input  logic        baln,
  input  logic        balrv,
  input  logic        jmxor,
  input  logic        jsp,
  input  logic        bgezal,
  input  logic        alu_zero,
  output npc_sel_t    npc_sel,
  output logic [31:0] next_pc
);

  logic [31:0] bt;
  logic [31:0] jt;
  logic        unused_opcode;

  assign bt = pc_plus4 + {{14{instruc[15]}}, instruc[15:0], 2'b00};
  assign jt = {pc_plus4[31:28], instruc[25:0], 2'b00};
  assign unused_opcode = ^instruc[31:26];

  // Priority select of the next-PC source; first match wins on overlap.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (jsp | jmxor)                npc_sel = NPC_MEM;
    else if (balrv & status[ST_V])  npc_sel = NPC_REG;
    else if (baln & status[ST_N])   npc_sel = NPC_JT;
    else if (bgezal & ~dataa[31])   npc_sel = NPC_BT;
    else if (branch & alu_zero)     npc_sel = NPC_BT;
  end

  // Mux the selected target.
  always_comb begin
    next_pc = pc_plus4;
    case (npc_sel)
      NPC_MEM: next_pc = mem_rdata;
      NPC_REG: next_pc = dataa;
      NPC_JT:  next_pc = jt;
      NPC_BT:  next_pc = bt;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_status_unit.sv
// Program counter and Z/N/V status register for the single-cycle core.
// Optional PC_ALIGN_CHECK_EN adds a sticky align_fault output that blocks
// loading of misaligned redirect targets and freezes pc/status.
module pc_status_unit
  import mips_ext_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter logic [2:0]  STATUS_RESET = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruc,
  input  logic        branch,
  input  logic        baln,
  input  logic        balrv,
  input  logic        jmxor,
  input  logic        jsp,
  input  logic        bgezal,
  input  logic        alu_zero,
  input  logic [31:0] dataa,
  input  logic [31:0] mem_rdata,
  input  logic        flag_we,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
`ifdef PC_ALIGN_CHECK_EN
  output logic        align_fault,
`endif
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [2:0]  status,
  output logic        redirect
);

  npc_sel_t    npc_sel;
  logic [31:0] next_pc;
  logic        advance;
  logic        pc_load;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = (npc_sel != NPC_SEQ);

  next_pc_sel u_next_pc_sel (
    .pc_plus4  (pc_plus4),
    .instruc   (instruc),
    .dataa     (dataa),
    .mem_rdata (mem_rdata),
    .status    (status),
    .branch    (branch),
    .baln      (baln),
    .balrv     (balrv),
    .jmxor     (jmxor),
    .jsp       (jsp),
    .bgezal    (bgezal),
    .alu_zero  (alu_zero),
    .npc_sel   (npc_sel),
    .next_pc   (next_pc)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misalign;

  assign misalign = redirect & (next_pc[1:0] != 2'b00);

  // Once faulted, nothing advances until reset.
  always_comb begin
    advance = ~stall & ~align_fault;
    pc_load = advance & ~misalign;
  end

  // Sticky alignment fault flag.
  always_ff @(posedge clk) begin
    if (reset)                    align_fault <= 1'b0;
    else if (advance & misalign)  align_fault <= 1'b1;
  end
`else
  // Every unstalled edge loads the selected target.
  always_comb begin
    advance = ~stall;
    pc_load = advance;
  end
`endif

  // PC register.
  always_ff @(posedge clk) begin
    if (reset)        pc <= RESET_PC;
    else if (pc_load) pc <= next_pc;
  end

  // Status register; current-cycle branch decisions see the pre-update value.
  always_ff @(posedge clk) begin
    if (reset)                  status <= STATUS_RESET;
    else if (advance & flag_we) status <= {alu_z, alu_n, alu_v};
  end

endmodule

// File: tb/tb_pc_status_unit.sv
// Self-checking bench for pc_status_unit (default build, no alignment check).
module tb_pc_status_unit;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] instruc, dataa, mem_rdata;
  logic        branch, baln, balrv, jmxor, jsp, bgezal, alu_zero;
  logic        flag_we, alu_z, alu_n, alu_v;
  logic [31:0] pc, pc_plus4;
  logic [2:0]  status;
  logic        redirect;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  st;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_pc;
  logic [2:0]  m_st;

  always #5 clk = ~clk;

  pc_status_unit #(
    .RESET_PC     (32'h0000_0000),
    .STATUS_RESET (3'b000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .instruc   (instruc),
    .branch    (branch),
    .baln      (baln),
    .balrv     (balrv),
    .jmxor     (jmxor),
    .jsp       (jsp),
    .bgezal    (bgezal),
    .alu_zero  (alu_zero),
    .dataa     (dataa),
    .mem_rdata (mem_rdata),
    .flag_we   (flag_we),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .alu_v     (alu_v),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .status    (status),
    .redirect  (redirect)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear();
    reset = 1'b0; stall = 1'b0; instruc = '0; dataa = '0; mem_rdata = '0;
    branch = 1'b0; baln = 1'b0; balrv = 1'b0; jmxor = 1'b0; jsp = 1'b0;
    bgezal = 1'b0; alu_zero = 1'b0; flag_we = 1'b0;
    alu_z = 1'b0; alu_n = 1'b0; alu_v = 1'b0;
  endtask

  // Reference next-PC from the bench's own pc/status copy.
  task automatic model(output logic [31:0] npc, output logic redir);
    logic [31:0] pp4, bt, jt;
    pp4 = m_pc + 32'd4;
    bt  = pp4 + {{14{instruc[15]}}, instruc[15:0], 2'b00};
    jt  = {pp4[31:28], instruc[25:0], 2'b00};
    redir = 1'b1;
    if (jsp || jmxor)              npc = mem_rdata;
    else if (balrv && m_st[0])     npc = dataa;
    else if (baln && m_st[1])      npc = jt;
    else if (bgezal && !dataa[31]) npc = bt;
    else if (branch && alu_zero)   npc = bt;
    else begin npc = pp4; redir = 1'b0; end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    logic [31:0] npc;
    logic        redir;
    exp_t        e, got;
    #1;
    model(npc, redir);
    if (!reset) begin
      check("redirect", {31'd0, redirect}, {31'd0, redir});
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
    end
    if (reset) begin
      e.pc = 32'h0; e.st = 3'b000;
    end else if (stall) begin
      e.pc = m_pc; e.st = m_st;
    end else begin
      e.pc = npc;
      e.st = flag_we ? {alu_z, alu_n, alu_v} : m_st;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("pc", pc, got.pc);
    check("status", {29'd0, status}, {29'd0, got.st});
    m_pc = got.pc;
    m_st = got.st;
    @(negedge clk);
  endtask

  task automatic go_to(input logic [31:0] a);
    clear(); jmxor = 1'b1; mem_rdata = a; cycle();
  endtask

  initial begin
    m_pc = '0; m_st = '0;
    clear();
    reset = 1'b1;
    jsp = 1'b1; mem_rdata = 32'h0000_1234;
    @(negedge clk);
    cycle();
    check("reset_pc", pc, 32'h0);
    check("reset_status", {29'd0, status}, 32'h0);

    for (int i = 0; i < 3; i++) begin
      clear(); cycle();
    end
    check("seq_pc", pc, 32'hC);

    go_to(32'h100);
    clear(); branch = 1'b1; alu_zero = 1'b1; instruc = 32'h0000_FFFE; cycle();
    check("beq_taken", pc, 32'hFC);
    go_to(32'h100);
    clear(); branch = 1'b1; alu_zero = 1'b0; instruc = 32'h0000_FFFE; cycle();
    check("beq_not_taken", pc, 32'h104);

    go_to(32'h20);
    clear(); flag_we = 1'b1; alu_n = 1'b1; cycle();
    check("flag_n", {29'd0, status}, 32'h2);
    clear(); baln = 1'b1; instruc = 32'h0000_0040; cycle();
    check("baln_taken", pc, 32'h100);
    go_to(32'h20);
    clear(); flag_we = 1'b1; cycle();
    clear(); baln = 1'b1; instruc = 32'h0000_0040; cycle();
    check("baln_not_taken", pc, 32'h28);

    clear(); flag_we = 1'b1; alu_v = 1'b1; balrv = 1'b1; dataa = 32'h200; cycle();
    check("balrv_same_cycle", pc, 32'h2C);
    clear(); balrv = 1'b1; dataa = 32'h200; cycle();
    check("balrv_taken", pc, 32'h200);

    clear(); stall = 1'b1; jmxor = 1'b1; mem_rdata = 32'h3000;
    flag_we = 1'b1; alu_z = 1'b1; cycle();
    check("stall_pc", pc, 32'h200);
    check("stall_status", {29'd0, status}, 32'h1);
    clear(); jmxor = 1'b1; mem_rdata = 32'h3000; cycle();
    check("jmxor", pc, 32'h3000);

    clear(); bgezal = 1'b1; dataa = 32'h8000_0000; instruc = 32'h4; cycle();
    check("bgezal_neg", pc, 32'h3004);
    clear(); bgezal = 1'b1; dataa = 32'h0; instruc = 32'h4; cycle();
    check("bgezal_taken", pc, 32'h3018);

    go_to(32'hFFFF_FFFC);
    clear(); cycle();
    check("wrap", pc, 32'h0);

    clear(); jsp = 1'b1; mem_rdata = 32'h500; branch = 1'b1; alu_zero = 1'b1;
    instruc = 32'h10; cycle();
    check("priority", pc, 32'h500);

    for (int i = 0; i < 80; i++) begin
      clear();
      reset     = ($urandom_range(0, 19) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      instruc   = $urandom;
      dataa     = $urandom;
      mem_rdata = $urandom;
      branch    = $urandom_range(0, 3) == 0;
      baln      = $urandom_range(0, 3) == 0;
      balrv     = $urandom_range(0, 3) == 0;
      jmxor     = $urandom_range(0, 7) == 0;
      jsp       = $urandom_range(0, 7) == 0;
      bgezal    = $urandom_range(0, 3) == 0;
      alu_zero  = $urandom_range(0, 1) == 1;
      flag_we   = $urandom_range(0, 1) == 1;
      alu_z     = $urandom_range(0, 1) == 1;
      alu_n     = $urandom_range(0, 1) == 1;
      alu_v     = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_status_unit.md
Name: pc_status_unit

Overview:
Sequential front end of the extended MIPS single-cycle datapath. It holds the program counter and the 3-bit status register (Z/N/V) that the main control decoder reads. Each cycle it consumes the decoder's branch/jump strobes and computes the next PC. It drives `pc` to instruction memory and `pc_plus4` to the register-file link path.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STATUS_RESET, 3'b000, status register value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and status this cycle
- instruc  in  32  current instruction; imm [15:0] and target [25:0] are used
- branch  in  1  beq strobe from decoder
- baln  in  1  baln strobe
- balrv  in  1  balrv strobe
- jmxor  in  1  jmxor strobe
- jsp  in  1  jsp strobe
- bgezal  in  1  bgezal strobe
- alu_zero  in  1  ALU zero result for beq
- dataa  in  32  register-file rs read value
- mem_rdata  in  32  data-memory read data; jump target for jmxor/jsp
- flag_we  in  1  current R-type ALU op updates status
- alu_z, alu_n, alu_v  in  1 each  ALU flags of current op
- pc  out  32  registered program counter
- pc_plus4  out  32  combinational pc+4, used as link value
- status  out  3  registered {Z,N,V}; bit0=V, bit1=N, bit2=Z
- redirect  out  1  combinational: next PC differs from pc_plus4 because of a taken control transfer

Behaviour:
- Reset (sync, high): pc<=RESET_PC, status<=STATUS_RESET. Reset overrides stall and all strobes; a redirect in the reset cycle is discarded.
- pc_plus4 = pc+32'd4, mod 2^32 (wraps from FFFF_FFFC to 0000_0000).
- Branch target bt = pc_plus4 + (sign-extend(instruc[15:0]) << 2), mod 2^32.
- Jump target jt = {pc_plus4[31:28], instruc[25:0], 2'b00}.
- next_pc priority, first match wins (the decoder guarantees at most one strobe; the priority resolves illegal overlap deterministically):
  1. jsp | jmxor -> mem_rdata
  2. balrv & status[0] -> dataa
  3. baln & status[1] -> jt
  4. bgezal & ~dataa[31] -> bt
  5. branch & alu_zero -> bt
  6. otherwise -> pc_plus4
- redirect=1 iff a case 1-5 is selected.
- On a rising edge with ~reset & ~stall: pc<=next_pc. With stall: pc holds and redirect is still computed but not applied.
- Status: on a rising edge with ~reset & ~stall & flag_we, status<={alu_z,alu_n,alu_v}; otherwise it holds.
- A baln/balrv that tests status sees the registered value from before that cycle's update. Same-cycle flag_we never affects the current branch decision.
- Latency: next_pc is combinational and pc updates one cycle later. Single-cycle core, so there are no bubbles.
- No alignment enforcement in the base build: targets with [1:0]!=0 are loaded as-is.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN
- Defined: adds output `align_fault` (1 bit, reset 0). If a selected redirect target has [1:0]!=0 on a non-stalled edge, pc holds its old value and align_fault is set sticky (cleared only by reset). While align_fault=1, pc is frozen and status is frozen.
- Undefined: port absent; targets loaded unchecked.

Decomposition:
- Shared package `mips_ext_pkg`:
  - status bit indices ST_V=0, ST_N=1, ST_Z=2
  - npc_sel enum {NPC_SEQ, NPC_MEM, NPC_REG, NPC_JT, NPC_BT}
  - RESET_PC default constant
- One combinational sub-module `next_pc_sel`: strobes, flags and targets in; npc_sel and next_pc out. The top holds the registers.

Test Plan:
- Reset, then 3 unstalled cycles with no strobes -> pc = 0, 4, 8, C. status = 000. redirect = 0.
- pc=0x100, beq with imm=0xFFFE, alu_zero=1 -> next pc = 0x100+4-8 = 0xFC. With alu_zero=0 -> 0x104.
- flag_we with N=1 at pc=0x20, then baln at pc=0x24 with target=0x40 -> pc=0x100. Same baln with status[1]=0 -> pc=0x28.
- flag_we (V=1) and balrv in the same cycle with prior status[0]=0 -> no redirect. Next-cycle balrv with dataa=0x200 -> pc=0x200.
- jmxor with mem_rdata=0x3000 while stall=1 -> pc unchanged, redirect=1. Stall released -> pc=0x3000.
- bgezal with dataa=0x8000_0000 -> pc_plus4. With dataa=0 and imm=4 -> pc+4+16. pc=0xFFFF_FFFC sequential -> wraps to 0.
